// File: rtl/imm_encode.sv
// Immediate encoder: rotated-8, 12-bit unsigned and branch-offset field encodings behind a valid/ready handshake.
// Define IMM_ENC_FAST_EN to evaluate all 16 rotations in parallel (single-cycle mode 00).
module imm_encode (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  input  logic [1:0]  ImmSrc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] Instr,
  output logic        enc_ok
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] value_q;
  logic [1:0]  src_q;

  logic        rot_hit;
  logic [3:0]  hit_rot;
  logic [7:0]  rot_imm;
  logic        last_try;

  logic        search_done;
  logic [23:0] next_instr;
  logic        next_ok;
  logic        branch_ok;

  // Rotate left by an even amount; the doubled word keeps a zero rotation well defined.
  function automatic logic [31:0] rol_even(input logic [31:0] v, input logic [3:0] r);
    logic [63:0] w;
    w = {v, v} << {r, 1'b0};
    return w[63:32];
  endfunction

`ifdef IMM_ENC_FAST_EN
  logic [31:0] cand;

  // Scan from the top so the smallest matching rotation overwrites any larger one.
  always_comb begin
    rot_hit = 1'b0;
    hit_rot = 4'd0;
    rot_imm = 8'd0;
    cand    = 32'd0;
    for (int i = 15; i >= 0; i--) begin
      cand = rol_even(value_q, 4'(i));
      if (cand[31:8] == 24'd0) begin
        rot_hit = 1'b1;
        hit_rot = 4'(i);
        rot_imm = cand[7:0];
      end
    end
  end

  assign last_try = 1'b1;
`else
  logic [3:0]  rot;
  logic [31:0] cand;

  always_comb begin
    cand    = rol_even(value_q, rot);
    rot_hit = (cand[31:8] == 24'd0);
    hit_rot = rot;
    rot_imm = cand[7:0];
  end

  assign last_try = (rot == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot <= 4'd0;
    end else if (state != SEARCH) begin
      rot <= 4'd0;
    end else if (!search_done) begin
      rot <= rot + 4'd1;
    end
  end
`endif

  // Branch offsets are word aligned and must sign-extend from bit 25.
  assign branch_ok = (value_q[1:0] == 2'b00) &&
                     ((value_q[31:25] == 7'h00) || (value_q[31:25] == 7'h7F));

  always_comb begin
    search_done = 1'b1;
    next_instr  = 24'd0;
    next_ok     = 1'b0;
    case (src_q)
      2'b00: begin
        if (rot_hit) begin
          next_instr = {12'd0, hit_rot, rot_imm};
          next_ok    = 1'b1;
        end else begin
          search_done = last_try;
        end
      end
      2'b01: begin
        if (value_q[31:12] == 20'd0) begin
          next_instr = {12'd0, value_q[11:0]};
          next_ok    = 1'b1;
        end
      end
      2'b10: begin
        if (branch_ok) begin
          next_instr = value_q[25:2];
          next_ok    = 1'b1;
        end
      end
      default: begin
        next_instr = 24'd0;
        next_ok    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      value_q   <= 32'd0;
      src_q     <= 2'b00;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Instr     <= 24'd0;
      enc_ok    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            value_q  <= value;
            src_q    <= ImmSrc;
            in_ready <= 1'b0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (search_done) begin
            Instr     <= next_instr;
            enc_ok    <= next_ok;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// Randomized self-checking bench for imm_encode against a decode-based reference model.
// Latency expectations follow IMM_ENC_FAST_EN when it is defined.
module tb_imm_encode;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic [1:0]  ImmSrc;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] Instr;
  logic        enc_ok;

  int assertCount = 0;
  int failCount   = 0;

  imm_encode dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .ImmSrc   (ImmSrc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Instr    (Instr),
    .enc_ok   (enc_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] x, input int s);
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  // Reference: the first rotation whose 8-bit immediate decodes back to the value wins.
  task automatic refModel(input logic [31:0] v, input logic [1:0] src,
                          output logic [23:0] instr, output logic ok, output int lat);
    logic [31:0] imm;
    instr = 24'd0;
    ok    = 1'b0;
    lat   = 1;
    case (src)
      2'b00: begin
`ifdef IMM_ENC_FAST_EN
        lat = 1;
`else
        lat = 16;
`endif
        for (int r = 0; r < 16; r++) begin
          imm = rol32(v, 2 * r) & 32'hFF;
          if (ror32(imm, 2 * r) == v) begin
            instr = 24'(r * 256 + imm);
            ok    = 1'b1;
`ifndef IMM_ENC_FAST_EN
            lat   = r + 1;
`endif
            break;
          end
        end
      end
      2'b01: if (v < 32'h1000) begin instr = v[23:0]; ok = 1'b1; end
      2'b10: begin
        if ((v % 4 == 0) && ($signed(v) >= -(32'sd1 << 25)) && ($signed(v) < (32'sd1 << 25))) begin
          instr = 24'(v / 4);
          ok    = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [31:0] v, input logic [1:0] src,
                               input logic [23:0] expInstr, input logic expOk,
                               input int expLat, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("idle_timeout", 32'(n), 32'd0);
    in_valid = 1'b1;
    value    = v;
    ImmSrc   = src;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      value    = $urandom;
      ImmSrc   = 2'($urandom_range(0, 3));
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checkOutput("latency", 32'(n), 32'(expLat));
    checkOutput("instr", 32'(Instr), 32'(expInstr));
    checkOutput("enc_ok", 32'(enc_ok), 32'(expOk));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_instr", 32'(Instr), 32'(expInstr));
      checkOutput("hold_ok", 32'(enc_ok), 32'(expOk));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic randomCase();
    logic [31:0] v;
    logic [1:0]  src;
    logic [23:0] ei;
    logic        eo;
    int          el;
    int          pick;
    src  = 2'($urandom_range(0, 3));
    pick = $urandom_range(0, 2);
    v    = $urandom;
    if (pick == 0) begin
      case (src)
        2'b00: v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
        2'b01: v = 32'($urandom_range(0, 4095));
        2'b10: begin
          v = 32'($signed(24'($urandom))) * 4;
        end
        default: ;
      endcase
    end else if (pick == 1) begin
      v = v >> $urandom_range(0, 31);
    end
    refModel(v, src, ei, eo, el);
    applyStimulus(v, src, ei, eo, el, $urandom_range(0, 3));
  endtask

  initial begin
    bit seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    value     = 32'd0;
    ImmSrc    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_instr", 32'(Instr), 32'd0);
    checkOutput("reset_enc_ok", 32'(enc_ok), 32'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef IMM_ENC_FAST_EN
    applyStimulus(32'h000000FF, 2'b00, 24'h0000FF, 1'b1, 1, 0);
    applyStimulus(32'hFF000000, 2'b00, 24'h0004FF, 1'b1, 1, 3);
    applyStimulus(32'h00000101, 2'b00, 24'h000000, 1'b0, 1, 1);
`else
    applyStimulus(32'h000000FF, 2'b00, 24'h0000FF, 1'b1, 1, 0);
    applyStimulus(32'hFF000000, 2'b00, 24'h0004FF, 1'b1, 5, 3);
    applyStimulus(32'h00000101, 2'b00, 24'h000000, 1'b0, 16, 1);
`endif
    applyStimulus(32'h00000ABC, 2'b01, 24'h000ABC, 1'b1, 1, 0);
    applyStimulus(32'h00001000, 2'b01, 24'h000000, 1'b0, 1, 0);
    applyStimulus(32'hFFFFFFF8, 2'b10, 24'hFFFFFE, 1'b1, 1, 2);
    applyStimulus(32'h00000006, 2'b10, 24'h000000, 1'b0, 1, 0);
    applyStimulus(32'h02000000, 2'b10, 24'h000000, 1'b0, 1, 0);
    applyStimulus(32'h01FFFFFC, 2'b10, 24'h7FFFFF, 1'b1, 1, 0);
    applyStimulus(32'h00000040, 2'b11, 24'h000000, 1'b0, 1, 0);

    for (int k = 0; k < 60; k++) randomCase();

    // Abort a request in flight and confirm no result ever appears.
    in_valid = 1'b1;
    value    = 32'h00000101;
    ImmSrc   = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifndef IMM_ENC_FAST_EN
    repeat (3) @(posedge clk);
    #1;
`endif
    checkOutput("pre_abort_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_instr", 32'(Instr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort_no_result", 32'(seen), 32'd0);
    checkOutput("abort_idle", 32'(in_ready), 32'd1);

    applyStimulus(32'h3FC00000, 2'b00, 24'h0005FF, 1'b1,
`ifdef IMM_ENC_FAST_EN
                  1,
`else
                  6,
`endif
                  0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
